// File: rtl/smoldvi_pattern_ctrl.sv
// Pixel-clock-domain pixel source and sequencer for the smoldvi encoder.
//
// After reset the encoder is held disabled for STARTUP_CYCLES pixel clocks, then enabled for good.
// While enabled, each rgb_rdy advances an x/y raster. The frame counter steps at every frame wrap.
// One of four test patterns is rendered combinationally from the raster state. The pattern only
// changes at a frame wrap, so every frame is drawn with a single pattern.
//
// Ports:
//   clk_pix     pixel clock, the only clock
//   rst_n_pix   synchronous active-low reset
//   btn_next    request next pattern (level, already synchronised; rising edge acts)
//   auto_cycle  advance the pattern every FRAMES_PER_PATTERN frames
//   rgb_rdy     encoder consumes the current r/g/b this cycle
//   dvi_en      encoder enable
//   r, g, b     current pixel
//   pattern     active pattern index
//   x, y        current pixel column / row
//   frame_ctr   frame count, wraps 255 -> 0
//   sof         high at pixel (0,0) while enabled
module smoldvi_pattern_ctrl #(
  parameter int unsigned H_ACTIVE           = 640,
  parameter int unsigned V_ACTIVE           = 480,
  parameter int unsigned STARTUP_CYCLES     = 1024,
  parameter int unsigned FRAMES_PER_PATTERN = 120
) (
  input  logic       clk_pix,
  input  logic       rst_n_pix,
  input  logic       btn_next,
  input  logic       auto_cycle,
  input  logic       rgb_rdy,
  output logic       dvi_en,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [1:0] pattern,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [7:0] frame_ctr,
  output logic       sof
);

  localparam int unsigned BarW = H_ACTIVE / 8;
  localparam int unsigned SuW  = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  typedef enum logic {StStartup, StRun} state_e;

  state_e         state_q;
  logic           dvi_en_q;
  logic [SuW-1:0] su_cnt_q;
  logic [9:0]     x_q;
  logic [8:0]     y_q;
  logic [7:0]     frame_q;
  logic [1:0]     pattern_q;
  logic           pending_q;
  logic [7:0]     auto_cnt_q;
  logic           btn_q;
  logic [9:0]     bar_px_q;
  logic [2:0]     bar_idx_q;

  logic advance, line_end, frame_end, frame_wrap, auto_req, btn_rise;

  assign advance    = (state_q == StRun) && rgb_rdy;
  assign line_end   = (x_q == 10'(H_ACTIVE - 1));
  assign frame_end  = (y_q == 9'(V_ACTIVE - 1));
  assign frame_wrap = advance && line_end && frame_end;
  assign auto_req   = auto_cycle && frame_wrap && (auto_cnt_q == 8'(FRAMES_PER_PATTERN - 1));
  assign btn_rise   = btn_next && !btn_q;

  always_ff @(posedge clk_pix) begin
    if (!rst_n_pix) begin
      state_q    <= StStartup;
      dvi_en_q   <= 1'b0;
      su_cnt_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      frame_q    <= '0;
      pattern_q  <= '0;
      pending_q  <= 1'b0;
      auto_cnt_q <= '0;
      btn_q      <= 1'b0;
      bar_px_q   <= '0;
      bar_idx_q  <= '0;
    end else begin
      btn_q <= btn_next;

      if (!auto_cycle) begin
        auto_cnt_q <= '0;
      end else if (frame_wrap) begin
        auto_cnt_q <= auto_req ? 8'd0 : auto_cnt_q + 8'd1;
      end

      // A button edge landing on the wrap cycle is folded into that wrap's advance.
      if (frame_wrap && (pending_q || btn_rise || auto_req)) begin
        pattern_q <= pattern_q + 2'd1;
        pending_q <= 1'b0;
      end else if (btn_rise) begin
        pending_q <= 1'b1;
      end

      unique case (state_q)
        StStartup: begin
          if (su_cnt_q == SuW'(STARTUP_CYCLES - 1)) begin
            state_q  <= StRun;
            dvi_en_q <= 1'b1;
          end else begin
            su_cnt_q <= su_cnt_q + SuW'(1);
          end
        end
        StRun: begin
          if (rgb_rdy) begin
            if (line_end) begin
              x_q       <= '0;
              bar_px_q  <= '0;
              bar_idx_q <= '0;
              if (frame_end) begin
                y_q     <= '0;
                frame_q <= frame_q + 8'd1;
              end else begin
                y_q <= y_q + 9'd1;
              end
            end else begin
              x_q <= x_q + 10'd1;
              // Bar index tracks x without a divider.
              if (bar_px_q == 10'(BarW - 1)) begin
                bar_px_q  <= '0;
                bar_idx_q <= bar_idx_q + 3'd1;
              end else begin
                bar_px_q <= bar_px_q + 10'd1;
              end
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    r = 8'h00;
    g = 8'h00;
    b = 8'h00;
    unique case (pattern_q)
      2'd0: begin
        r = x_q[7:0] + frame_q;
        g = y_q[7:0] + {frame_q[6:0], 1'b0};
        b = frame_q;
      end
      2'd1: begin
        // Bars 0..7 run white, yellow, cyan, green, magenta, red, blue, black.
        r = {8{~bar_idx_q[1]}};
        g = {8{~bar_idx_q[2]}};
        b = {8{~bar_idx_q[0]}};
      end
      2'd2: begin
        r = {8{x_q[4] ^ y_q[4]}};
        g = r;
        b = r;
      end
      2'd3: begin
        r = frame_q;
        g = frame_q;
        b = frame_q;
      end
    endcase
  end

  assign dvi_en    = dvi_en_q;
  assign pattern   = pattern_q;
  assign x         = x_q;
  assign y         = y_q;
  assign frame_ctr = frame_q;
  assign sof       = dvi_en_q && (x_q == 10'd0) && (y_q == 9'd0);

endmodule

// File: tb/tb_smoldvi_pattern_ctrl.sv
// Bench for smoldvi_pattern_ctrl: a small-raster instance (16x4) and a full-width instance
// (640x2) run side by side against a behavioural model, plus directed boundary checks.
module tb_smoldvi_pattern_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic s_rst_n, s_btn, s_auto, s_rdy;
  logic l_rst_n, l_btn, l_auto, l_rdy;
  logic       s_dvi_en, l_dvi_en, s_sof, l_sof;
  logic [7:0] s_r, s_g, s_b, l_r, l_g, l_b, s_frame_ctr, l_frame_ctr;
  logic [1:0] s_pattern, l_pattern;
  logic [9:0] s_x, l_x;
  logic [8:0] s_y, l_y;

  smoldvi_pattern_ctrl #(
    .H_ACTIVE(16), .V_ACTIVE(4), .STARTUP_CYCLES(8), .FRAMES_PER_PATTERN(2)
  ) u_small (
    .clk_pix(clk), .rst_n_pix(s_rst_n), .btn_next(s_btn), .auto_cycle(s_auto),
    .rgb_rdy(s_rdy), .dvi_en(s_dvi_en), .r(s_r), .g(s_g), .b(s_b), .pattern(s_pattern),
    .x(s_x), .y(s_y), .frame_ctr(s_frame_ctr), .sof(s_sof)
  );

  smoldvi_pattern_ctrl #(
    .H_ACTIVE(640), .V_ACTIVE(2), .STARTUP_CYCLES(8), .FRAMES_PER_PATTERN(1)
  ) u_large (
    .clk_pix(clk), .rst_n_pix(l_rst_n), .btn_next(l_btn), .auto_cycle(l_auto),
    .rgb_rdy(l_rdy), .dvi_en(l_dvi_en), .r(l_r), .g(l_g), .b(l_b), .pattern(l_pattern),
    .x(l_x), .y(l_y), .frame_ctr(l_frame_ctr), .sof(l_sof)
  );

  // Behavioural reference: pixel position, frame count and pattern as plain integers.
  typedef struct {
    int unsigned h, v, su, fpp;
    int unsigned cyc, x, y, fr, pat, acnt;
    bit pend, prev;
  } mdl_t;

  mdl_t ms, ml;
  int nvec = 0;
  int nerr = 0;
  int unsigned bar_rgb [8] = '{7, 6, 3, 2, 5, 4, 1, 0};
  int unsigned t5_exp [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  function automatic mdl_t mstep(mdl_t m, bit rst_n, bit btn, bit au, bit rdy);
    bit rise, wrap, req;
    if (!rst_n) begin
      m.cyc = 0; m.x = 0; m.y = 0; m.fr = 0; m.pat = 0; m.acnt = 0; m.pend = 0; m.prev = 0;
      return m;
    end
    rise = btn && !m.prev;
    m.prev = btn;
    wrap = 0;
    req = 0;
    if (m.cyc < m.su) begin
      m.cyc++;
    end else if (rdy) begin
      m.x++;
      if (m.x == m.h) begin
        m.x = 0;
        m.y++;
        if (m.y == m.v) begin
          m.y = 0;
          m.fr = (m.fr + 1) % 256;
          wrap = 1;
        end
      end
    end
    if (!au) m.acnt = 0;
    else if (wrap) begin
      m.acnt++;
      if (m.acnt == m.fpp) begin
        req = 1;
        m.acnt = 0;
      end
    end
    if (wrap && (m.pend || rise || req)) begin
      m.pat = (m.pat + 1) % 4;
      m.pend = 0;
    end else if (rise) m.pend = 1;
    return m;
  endfunction

  function automatic logic [54:0] mexp(mdl_t m);
    logic en;
    logic [7:0] r, g, b, fr8;
    int unsigned code;
    en = (m.cyc == m.su);
    fr8 = 8'(m.fr);
    case (m.pat)
      0: begin
        r = 8'((m.x + m.fr) % 256);
        g = 8'((m.y + 2 * m.fr) % 256);
        b = fr8;
      end
      1: begin
        code = bar_rgb[m.x / (m.h / 8)];
        r = code[2] ? 8'hFF : 8'h00;
        g = code[1] ? 8'hFF : 8'h00;
        b = code[0] ? 8'hFF : 8'h00;
      end
      2: begin
        r = (((m.x / 16) % 2) != ((m.y / 16) % 2)) ? 8'hFF : 8'h00;
        g = r;
        b = r;
      end
      default: begin
        r = fr8;
        g = fr8;
        b = fr8;
      end
    endcase
    return {en, r, g, b, 2'(m.pat), 10'(m.x), 9'(m.y), fr8, (en && m.x == 0 && m.y == 0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance both models on the edge, then compare both DUTs just after it.
  task automatic cycle();
    @(posedge clk);
    ms = mstep(ms, s_rst_n, s_btn, s_auto, s_rdy);
    ml = mstep(ml, l_rst_n, l_btn, l_auto, l_rdy);
    #1;
    chk("small_model", {s_dvi_en, s_r, s_g, s_b, s_pattern, s_x, s_y, s_frame_ctr, s_sof},
        mexp(ms));
    chk("large_model", {l_dvi_en, l_r, l_g, l_b, l_pattern, l_x, l_y, l_frame_ctr, l_sof},
        mexp(ml));
  endtask

  initial begin
    ms.h = 16;  ms.v = 4; ms.su = 8; ms.fpp = 2;
    ml.h = 640; ml.v = 2; ml.su = 8; ml.fpp = 1;
    ms = mstep(ms, 1'b0, 1'b0, 1'b0, 1'b0);
    ml = mstep(ml, 1'b0, 1'b0, 1'b0, 1'b0);
    s_rst_n = 0; s_btn = 0; s_auto = 0; s_rdy = 0;
    l_rst_n = 0; l_btn = 0; l_auto = 0; l_rdy = 0;
    repeat (2) cycle();
    chk("reset_state", {s_dvi_en, s_pattern, s_x, s_y, s_frame_ctr, s_sof}, 64'd0);

    // Start-up: enable rises on the 8th edge after release; raster holds meanwhile.
    s_rst_n = 1; s_rdy = 1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk("t1_dvi_en", s_dvi_en, (k == 8) ? 64'd1 : 64'd0);
      chk("t1_x_hold", s_x, 64'd0);
    end
    cycle();
    chk("t1_first_px", s_x, 64'd1);

    // Line and frame wrap.
    repeat (14) cycle();
    chk("t2_line_end", {s_x, s_y}, {10'd15, 9'd0});
    cycle();
    chk("t2_line_wrap", {s_x, s_y}, {10'd0, 9'd1});
    repeat (47) cycle();
    chk("t2_last_px", {s_x, s_y, s_frame_ctr}, {10'd15, 9'd3, 8'd0});
    cycle();
    chk("t2_frame_wrap", {s_x, s_y, s_frame_ctr, s_sof}, {10'd0, 9'd0, 8'd1, 1'b1});

    // Stall: frame 1 gradient gives r=x+1, g=2, b=1.
    cycle();
    chk("t3_rdy1", {s_x, s_r, s_g, s_b}, {10'd1, 24'h020201});
    s_rdy = 0;
    cycle();
    chk("t3_stall_a", {s_x, s_r, s_g, s_b}, {10'd1, 24'h020201});
    cycle();
    chk("t3_stall_b", {s_x, s_r, s_g, s_b}, {10'd1, 24'h020201});
    s_rdy = 1;
    cycle();
    chk("t3_rdy2", {s_x, s_r, s_g, s_b}, {10'd2, 24'h030201});

    // Button: pending from (5,1), second edge on the wrap cycle gives one advance only.
    repeat (19) cycle();
    chk("t4_at_5_1", {s_x, s_y}, {10'd5, 9'd1});
    s_btn = 1;
    cycle();
    s_btn = 0;
    chk("t4_pending_hold", s_pattern, 64'd0);
    repeat (41) cycle();
    chk("t4_before_wrap", {s_x, s_y, s_pattern}, {10'd15, 9'd3, 2'd0});
    s_btn = 1;
    cycle();
    s_btn = 0;
    chk("t4_single_adv", {s_pattern, s_frame_ctr, s_x}, {2'd1, 8'd2, 10'd0});
    repeat (64) cycle();
    chk("t4_no_extra", s_pattern, 64'd1);

    // Mid-frame reset, then auto advance every two frames.
    repeat (10) cycle();
    s_rst_n = 0;
    cycle();
    chk("t5_reset", {s_dvi_en, s_pattern, s_x, s_y, s_frame_ctr}, 64'd0);
    s_rst_n = 1; s_auto = 1;
    repeat (8) cycle();
    chk("t5_enabled", s_dvi_en, 64'd1);
    for (int f = 0; f < 9; f++) begin
      chk("t5_auto_pattern", s_pattern, 64'(t5_exp[f]));
      chk("t5_frame", s_frame_ctr, 64'(f));
      repeat (64) cycle();
    end

    // Randomised traffic on the small instance.
    for (int i = 0; i < 1500; i++) begin
      s_rdy   = ($urandom_range(0, 3) != 0);
      s_btn   = ($urandom_range(0, 99) < 3);
      s_rst_n = ($urandom_range(0, 999) != 0);
      if (i % 300 == 0) s_auto = 1'($urandom_range(0, 1));
      cycle();
    end
    s_rdy = 0; s_btn = 0;

    // Full-width colour bars; button edge during start-up is remembered.
    l_rst_n = 1; l_rdy = 1; l_btn = 1;
    cycle();
    l_btn = 0;
    repeat (7) cycle();
    chk("t6_enabled", {l_dvi_en, l_x}, {1'b1, 10'd0});
    repeat (1280) cycle();
    chk("t6_bars_sel", {l_pattern, l_frame_ctr, l_x}, {2'd1, 8'd1, 10'd0});
    repeat (79) cycle();
    chk("t6_x79", {l_x, l_r, l_g, l_b}, {10'd79, 24'hFFFFFF});
    cycle();
    chk("t6_x80", {l_x, l_r, l_g, l_b}, {10'd80, 24'hFFFF00});
    repeat (559) cycle();
    chk("t6_x639", {l_x, l_r, l_g, l_b}, {10'd639, 24'h000000});
    cycle();
    chk("t6_line2_bar0", {l_x, l_y, l_r, l_g, l_b}, {10'd0, 9'd1, 24'hFFFFFF});
    repeat (300) cycle();
    chk("t6_x300", l_x, 64'd300);
    l_rst_n = 0;
    cycle();
    chk("t6_reset", {l_dvi_en, l_pattern, l_x, l_y, l_frame_ctr, l_sof}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
